// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores against a word-wide memory with a registered read port.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | waiting for a request
// RD    | memory read cycle (cs=1, we=0)
// CAP   | read data arrives; capture for a load or merge for a sub-word store
// WR    | memory write cycle (cs=1, we=1)
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  wr,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

   state_t                state, state_nxt;
   logic                  wr_q, sign_q;
   logic [1:0]            size_q, off_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  accept, misalign;
   logic                  cs_nxt, we_nxt, done_nxt, err_nxt;
   logic [4:0]            sh;
   logic [DATA_WIDTH-1:0] shifted, load_val, lane_mask, merged;
   logic                  unused_addr;

   assign unused_addr = ^addr[31:ADDR_WIDTH+2];
   assign accept      = req && (state == IDLE);
   assign busy        = (state != IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !misalign) state_nxt = (wr && size[1]) ? WR : RD;
         RD:      state_nxt = CAP;
         CAP:     state_nxt = wr_q ? WR : IDLE;
         WR:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cs_nxt   = (state_nxt == RD) || (state_nxt == WR);
      we_nxt   = (state_nxt == WR);
      done_nxt = ((state == CAP) && !wr_q) || (state == WR) || (accept && misalign);
      err_nxt  = accept && misalign;
   end

   // Big-endian lanes: byte offset 0 and half offset 0 sit in the high bits.
   always_comb begin
      sh = 5'd0;
      if (size_q == 2'b00)      sh = {~off_q, 3'b000};
      else if (size_q == 2'b01) sh = off_q[1] ? 5'd0 : 5'd16;
   end

   assign shifted   = mem_dout >> sh;
   assign lane_mask = (size_q == 2'b01) ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(8'hFF);
   assign merged    = (mem_dout & ~(lane_mask << sh)) | ((wdata_q & lane_mask) << sh);

   always_comb begin
      case (size_q)
         2'b00:   load_val = {{(DATA_WIDTH-8){sign_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = {{(DATA_WIDTH-16){sign_q & shifted[15]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_cs   <= 1'b0;
         mem_we   <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
         wr_q     <= 1'b0;
         sign_q   <= 1'b0;
         size_q   <= 2'b00;
         off_q    <= 2'b00;
         wdata_q  <= '0;
      end else begin
         mem_cs <= cs_nxt;
         mem_we <= we_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
         if (accept && !misalign) begin
            wr_q     <= wr;
            sign_q   <= sign_ext;
            size_q   <= size;
            off_q    <= addr[1:0];
            wdata_q  <= wdata;
            mem_addr <= addr[ADDR_WIDTH+1:2];
            mem_din  <= wdata;
         end
         if (state == CAP) begin
            if (wr_q) mem_din <= merged;
            else      rdata   <= load_val;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic against a byte-array memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0, wr = 1'b0, sign_ext = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic        busy, done, err, mem_cs, mem_we;
   logic [31:0] rdata, mem_din, mem_dout;
   logic [9:0]  mem_addr;

   logic [31:0] sim_mem [1024];
   logic [7:0]  ref_b   [4096];
   int          n_chk = 0, n_pass = 0, n_writes = 0;
   logic [31:0] last_rd = '0;
   logic        poke = 1'b0;
   logic [7:0]  seq;
   logic [31:0] din_wr;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) begin
            sim_mem[mem_addr] <= mem_din;
            n_writes <= n_writes + 1;
         end else begin
            mem_dout <= sim_mem[mem_addr];
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (a[11:0] % nbytes(sz)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int eff_addr(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      return (a % 4096) / n * n;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
      int n = nbytes(sz);
      int ea = eff_addr(sz, a);
      logic [31:0] v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[ea + i]);
      if (n < 4 && sx && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int n = nbytes(sz);
      int ea = eff_addr(sz, a);
      for (int i = 0; i < n; i++) ref_b[ea + i] = 8'(d >> (8 * (n - 1 - i)));
   endtask

   function automatic logic [31:0] model_word(input int w);
      return {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]};
   endfunction

   task automatic set_word(input int w, input logic [31:0] v);
      sim_mem[w] = v;
      for (int i = 0; i < 4; i++) ref_b[4*w+i] = 8'(v >> (24 - 8*i));
   endtask

   // Called at a negedge; returns at the negedge where done was observed.
   task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
      logic mis = is_mis(sz, a);
      int exp_lat = mis ? 1 : (!w ? 3 : (nbytes(sz) == 4 ? 2 : 4));
      int lat = 0, busy_cnt = 0, wr0 = n_writes;
      logic saw_done = 0, saw_err = 0;
      logic [31:0] exp_rd = last_rd, exp_din = '0;
      if (!mis) begin
         if (!w) exp_rd = model_load(sz, sx, a);
         else begin
            model_store(sz, a, d);
            exp_din = model_word(eff_addr(sz, a) / 4);
         end
      end
      seq = '0; din_wr = '0;
      req = 1; wr = w; size = sz; sign_ext = sx; addr = a; wdata = d;
      while (lat < 10 && !saw_done) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            req = poke;
            wr = poke ? 1'b1 : 1'($urandom);
            size = poke ? 2'b10 : 2'($urandom);
            sign_ext = 1'($urandom);
            addr = poke ? 32'h40 : $urandom;
            wdata = poke ? 32'hDEADBEEF : $urandom;
         end else begin
            req = 0;
         end
         seq = {seq[5:0], mem_cs, mem_we};
         if (busy) busy_cnt++;
         if (done) saw_done = 1;
         if (err) saw_err = 1;
         if (mem_cs && mem_we) din_wr = mem_din;
      end
      req = 0;
      check_val("latency", lat, exp_lat);
      check_val("done", 32'(saw_done), 1);
      check_val("err", 32'(saw_err), 32'(mis));
      check_val("busy_cycles", busy_cnt, exp_lat - 1);
      check_val("write_count", n_writes - wr0, (w && !mis) ? 1 : 0);
      if (!w) check_val("rdata", rdata, exp_rd);
      if (w && !mis) check_val("mem_din_wr", din_wr, exp_din);
      last_rd = exp_rd;
   endtask

   initial begin
      logic dn;
      int wr0;
      for (int i = 0; i < 1024; i++) set_word(i, 32'h0);
      repeat (2) @(negedge clk);
      check_val("reset_ctrl", {27'b0, busy, done, err, mem_cs, mem_we}, 0);
      check_val("reset_rdata", rdata, 0);
      check_val("reset_bus", {mem_addr, mem_din[21:0]} | 32'(mem_din[31:22]), 0);
      rst = 0;
      @(negedge clk);
      set_word(0, 32'h000007D1);
      set_word(1, 32'h00000FA1);

      do_op(0, 2'b10, 0, 32'd0, 0);
      check_val("ld_word0", rdata, 32'h000007D1);
      do_op(0, 2'b00, 1, 32'd3, 0);
      check_val("ld_byte_sx", rdata, 32'hFFFFFFD1);
      do_op(0, 2'b00, 0, 32'd3, 0);
      check_val("ld_byte_zx", rdata, 32'h000000D1);
      do_op(0, 2'b01, 1, 32'd2, 0);
      check_val("ld_half_sx", rdata, 32'h000007D1);

      do_op(1, 2'b00, 0, 32'd5, 32'h000000AB);
      check_val("sb_seq", seq, 8'b10_00_11_00);
      check_val("sb_din", din_wr, 32'h00AB0FA1);
      do_op(0, 2'b10, 0, 32'd4, 0);
      check_val("ld_after_sb", rdata, 32'h00AB0FA1);

      do_op(1, 2'b10, 0, 32'd8, 32'h12345678);
      do_op(0, 2'b10, 0, 32'd8, 0);
      check_val("b2b_rd", rdata, 32'h12345678);

      poke = 1;
      do_op(0, 2'b10, 0, 32'd0, 0);
      poke = 0;
      repeat (3) @(negedge clk);
      check_val("poke_ignored", sim_mem[16], 32'h0);

      wr0 = n_writes;
      req = 1; wr = 1; size = 2'b00; sign_ext = 0; addr = 32'd9; wdata = 32'h55;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         req = 0;
      end
      check_val("rst_pre_wr", {30'b0, mem_cs, mem_we}, 3);
      rst = 1;
      #1;
      check_val("rst_ctrl", {27'b0, busy, done, err, mem_cs, mem_we}, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_din", mem_din, 0);
      check_val("rst_addr", 32'(mem_addr), 0);
      dn = 0;
      @(negedge clk);
      rst = 0;
      repeat (4) begin
         @(negedge clk);
         dn = dn | done;
      end
      check_val("rst_no_done", 32'(dn), 0);
      check_val("rst_no_write", n_writes - wr0, 0);
      check_val("rst_word_kept", sim_mem[2], 32'h12345678);
      last_rd = '0;

      do_op(0, 2'b01, 1, 32'd1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check_val("mis_half_rd", rdata, 32'h0);
      check_val("mis_no_cs", 32'(seq[1]), 0);
`else
      check_val("mis_half_rd", rdata, 32'h00000000);
`endif

      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = {$urandom_range(0, 1048575), 12'(0)} | 32'($urandom_range(0, 63));
         do_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      end
      for (int w = 0; w < 16; w++) check_val("final_mem", sim_mem[w], model_word(w));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the MIPS datapath, placed between the pipeline MEM stage and the word-organised data memory. It takes one load or store request at a time with a byte address and an access size (byte, half or word), and drives the memory's chip-select, write-enable, word address and write data. Loads are extracted and sign- or zero-extended from the memory's registered read port. Sub-word stores use a read-modify-write sequence, because the memory has no byte enables.

## Interface
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 10, memory word-address width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only when busy=0.
- wr  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  CPU byte address.
- wdata  in  DATA_WIDTH  store data, right-aligned for byte and half.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle misalignment pulse (see Configuration).
- rdata  out  DATA_WIDTH  load result; holds its value until the next load completes.
- mem_cs, mem_we  out  1  memory chip-select and write-enable (registered).
- mem_addr  out  ADDR_WIDTH  memory word address, equal to addr[ADDR_WIDTH+1:2]; upper bits are ignored (wrap).
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data, valid from the edge after a read-select edge.

## Operation
- Byte order is big-endian:
  - Byte offset 0 → bits 31:24, offset 3 → bits 7:0.
  - Half offset addr[1]=0 → bits 31:16, addr[1]=1 → bits 15:0.
- Accepted request fields (wr, size, sign_ext, addr, wdata) are latched at acceptance. Input changes after that have no effect.
- FSM states are IDLE, RD, CAP and WR. busy = (state != IDLE).
  - IDLE: on req, go to WR for a word store, otherwise go to RD.
  - RD: mem_cs=1, mem_we=0. Next state is CAP.
  - CAP: mem_cs=0. Capture mem_dout at the exit edge.
    - Load: write the extracted and extended value to rdata, pulse done, go to IDLE.
    - Sub-word store: merge the latched data into the target lane of the captured word, load mem_din, go to WR.
  - WR: mem_cs=1, mem_we=1. Next state is IDLE with a done pulse.
- mem_cs and mem_we are 0 in IDLE and CAP.
- mem_addr and mem_din are held stable for the whole request.
- A req seen while busy=1 is ignored and not queued.
- A new req may be accepted in the same cycle that done is high (back-to-back operation).

## Timing
- All latencies count edges from the acceptance edge E0:
  - Word store: memory write at E1, done high in the E1–E2 cycle.
  - Load: read at E1, capture at E2, done and new rdata visible in the E2–E3 cycle.
  - Sub-word store: read at E1, merge at E2, write at E3, done in the E3–E4 cycle.
- Reset values: state=IDLE; busy, done, err, mem_cs and mem_we all 0; rdata, mem_addr and mem_din all 0.
- Reset mid-operation:
  - The operation is aborted immediately.
  - mem_cs and mem_we drop asynchronously, so no write occurs at any later edge.
  - No done pulse is generated.
  - rdata is cleared.

## Configuration
- Macro LSU_MISALIGN_TRAP_EN.
- When defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is accepted but issues no memory cycle.
  - done and err both pulse in the E0–E1 cycle.
  - rdata and memory contents are unchanged.
- When undefined:
  - Offending low address bits are ignored: a half access uses addr[1], a word access ignores addr[1:0].
  - err is tied to 0.

## Test plan
- Memory word 0 = 0x000007D1. Load word at addr 0 → rdata=0x000007D1. done in the E2–E3 cycle, busy high for exactly 2 cycles.
- Load byte at addr 3:
  - sign_ext=1 → rdata=0xFFFFFFD1.
  - sign_ext=0 → 0x000000D1.
  - Load half at addr 2, sign_ext=1 → 0x000007D1.
- Word 1 = 0x00000FA1. Store byte 0xAB at addr 5:
  - Required memory sequence: read, idle, write.
  - mem_din = 0x00AB0FA1 during WR.
  - A subsequent word load at addr 4 returns 0x00AB0FA1.
- Back-to-back traffic:
  - Store word 0x12345678 at addr 8, then load addr 8 issued in the done cycle → rdata=0x12345678.
  - A req pulsed while busy=1 produces no memory activity.
- Assert rst during the WR cycle of a sub-word store → no write reaches memory, the word keeps its old value, done is never pulsed, all outputs are 0.
- Load half at addr 1:
  - With LSU_MISALIGN_TRAP_EN: err=1 and done=1 in the E0–E1 cycle, mem_cs never asserted.
  - Without the macro: access is treated as addr 0 → rdata=0x00000000 for word 0 = 0x000007D1.
